bus_dma_arbiter: RTL and testbench
==================================

BUS_DMA_ARBITER -- requirements
Module: bus_dma_arbiter

Interface
REQ-001 Parameter ROTATE, default 1, meaning: 1 = rotating priority, 0 = fixed priority with channel 0 highest.
REQ-002 Parameter MAX_BEATS, default 16, meaning: maximum granted beats per bus tenure (legal range 1..31).
REQ-003 Port clk  input  1  meaning: the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  meaning: reset, asynchronous, active-low.
REQ-005 Port dreq  input  4  meaning: DMA channel requests, level-sensitive, bit n = channel n.
REQ-006 Port hlda  input  1  meaning: hold acknowledge from the processor.
REQ-007 Port hold  output  1  meaning: bus request to the processor.
REQ-008 Port dack  output  4  meaning: one-hot channel grant.
REQ-009 Port busy  output  1  meaning: arbiter is not in IDLE.
REQ-010 Port abort  output  1  meaning: one-cycle pulse, tenure ended by loss of hlda.
REQ-011 Port state  output  2  meaning: debug copy of the FSM state (IDLE=0, REQ=1, GRANT=2, RELEASE=3).

Function
REQ-012 Moore FSM with states IDLE, REQ, GRANT and RELEASE; hold, dack, busy and state SHALL decode from the state register and registered winner only, with no input-to-output combinational path.
REQ-013 IDLE: if dreq != 0, next state SHALL be REQ; otherwise it SHALL remain IDLE.
REQ-014 REQ: hold=1, dack=0.
- hlda=1 and dreq != 0: register winner, clear beat counter, go to GRANT.
- dreq == 0 (requests withdrawn): go to RELEASE.
- Otherwise remain in REQ, with no timeout.
REQ-015 Winner selection, ROTATE=0: lowest-numbered asserted dreq bit.
REQ-016 Winner selection, ROTATE=1: search starts at (last_winner+1) mod 4 and wraps; last_winner resets to 3, so the first search starts at channel 0.
REQ-017 last_winner SHALL update only on REQ->GRANT.
REQ-018 GRANT: hold=1, dack=one-hot(winner).
- Beat counter (5 bits) increments each cycle dreq[winner]=1.
REQ-019 GRANT exit, evaluated each cycle, priority order:
- (a) hlda=0: go to RELEASE and pulse abort=1 on the following cycle.
- (b) dreq[winner]=0: go to RELEASE.
- (c) beat counter == MAX_BEATS-1 with dreq[winner]=1, i.e. the MAX_BEATS-th beat: go to RELEASE.
- Otherwise remain in GRANT.
REQ-020 Requests from non-winning channels during GRANT SHALL be ignored; they wait for a new tenure.
REQ-021 RELEASE: hold=0, dack=0.
- hlda=0: go to IDLE.
- Otherwise remain in RELEASE.
REQ-022 After RELEASE the FSM SHALL spend at least one cycle in IDLE with hold=0 before re-asserting hold, guaranteeing the processor one bus window per tenure.
REQ-023 dack SHALL never have more than one bit set, and SHALL be 0 whenever hold=0.
REQ-024 busy SHALL be 1 in REQ, GRANT and RELEASE.
REQ-025 abort SHALL be 1 for exactly one cycle per hlda-loss event, and 0 otherwise.
REQ-026 Beat counter arithmetic SHALL be unsigned 5-bit; the counter SHALL never exceed MAX_BEATS-1 and never wrap.

Reset
REQ-027 While rst=0, asynchronously:
- state=IDLE, hold=0, dack=0, busy=0, abort=0.
- Beat counter=0, winner=0, last_winner=3.
REQ-028 Reset asserted mid-tenure SHALL drop hold and dack in the same instant, without passing through RELEASE.
REQ-029 After rst rises, the first transition SHALL occur on the next clk edge, using the IDLE rules.

Verification
REQ-030 Fixed priority (ROTATE=0): dreq=4'b0110, hlda returned 2 cycles after hold -> dack=4'b0010; hold high until dreq[1] drops; RELEASE; hlda=0 -> IDLE one cycle -> hold re-asserted, then dack=4'b0100.
REQ-031 Rotation (ROTATE=1): dreq=4'b1111 held continuously, MAX_BEATS=4 -> successive tenures grant dack=0001, 0010, 0100, 1000, 0001; each tenure lasts exactly 4 GRANT cycles; hold=0 for at least 1 cycle between tenures.
REQ-032 Beat limit: MAX_BEATS=16, dreq[2] held high -> exactly 16 cycles with dack=4'b0100, then hold=0 with dack=0.
REQ-033 Abort: in GRANT, drive hlda=0 -> next cycle hold=0, dack=0, abort=1 for 1 cycle; the FSM reaches IDLE once hlda stays 0.
REQ-034 Withdraw in REQ: dreq=4'b0001 for 1 cycle then 0, with hlda never asserted -> REQ -> RELEASE -> IDLE; dack stays 0 throughout.
REQ-035 Async reset: assert rst=0 mid-GRANT, between clock edges -> hold=0, dack=0, busy=0 immediately; after release, dreq=0 -> the FSM stays in IDLE.

Source files
------------

// File: rtl/bus_dma_arbiter.sv
// bus_dma_arbiter: 4-channel DMA bus arbiter, hold/hlda handshake, fixed or rotating priority, beat-limited tenures
module bus_dma_arbiter #(
  parameter int ROTATE    = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dreq,
  input  logic       hlda,
  output logic       hold,
  output logic [3:0] dack,
  output logic       busy,
  output logic       abort,
  output logic [1:0] state
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, GRANT = 2'd2, RELEASE = 2'd3;
  localparam logic [4:0] LAST = 5'(MAX_BEATS - 1);
  logic [1:0] nxt, winner, last_winner, base, pick;
  logic [3:0] rot;
  logic [4:0] beats;
  logic       win_req, at_limit;
  // rotate the request vector so the search always starts at bit 0, then undo the offset
  assign base     = ROTATE != 0 ? last_winner + 2'd1 : 2'd0;
  assign rot      = 4'({dreq, dreq} >> base);
  assign pick     = base + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  assign win_req  = dreq[winner];
  assign at_limit = beats == LAST;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |dreq ? REQ : IDLE;
      REQ:     nxt = (hlda && |dreq) ? GRANT : ~|dreq ? RELEASE : REQ;
      GRANT:   nxt = (!hlda || !win_req || at_limit) ? RELEASE : GRANT;
      default: nxt = hlda ? RELEASE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      winner      <= 2'd0;
      last_winner <= 2'd3;
      beats       <= 5'd0;
      abort       <= 1'b0;
    end else begin
      state <= nxt;
      abort <= state == GRANT && !hlda;
      if (state == REQ && nxt == GRANT) begin
        winner      <= pick;
        last_winner <= pick;
        beats       <= 5'd0;
      end else if (state == GRANT && hlda && win_req && !at_limit) begin
        beats <= beats + 5'd1;
      end
    end
  end
  assign hold = state == REQ || state == GRANT;
  assign dack = state == GRANT ? 4'b0001 << winner : 4'b0000;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_bus_dma_arbiter.sv
// tb_bus_dma_arbiter: directed scoreboard bench for fixed-priority and rotating arbiter instances
module tb_bus_dma_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fd, rd;
  logic       fh, rh;
  logic       f_hold, f_busy, f_abort, r_hold, r_busy, r_abort;
  logic [3:0] f_dack, r_dack;
  logic [1:0] f_state, r_state;
  logic [3:0] exp_q[$];
  int         errors = 0, checks = 0;
  int         cnt, gap;

  always #5 clk = ~clk;

  bus_dma_arbiter #(.ROTATE(0), .MAX_BEATS(16)) u_fix (
    .clk(clk), .rst(rst), .dreq(fd), .hlda(fh), .hold(f_hold), .dack(f_dack),
    .busy(f_busy), .abort(f_abort), .state(f_state));

  bus_dma_arbiter #(.ROTATE(1), .MAX_BEATS(4)) u_rot (
    .clk(clk), .rst(rst), .dreq(rd), .hlda(rh), .hold(r_hold), .dack(r_dack),
    .busy(r_busy), .abort(r_abort), .state(r_state));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_grant(input string tag, input logic [3:0] obs);
    logic [3:0] e;
    e = exp_q.size() != 0 ? exp_q.pop_front() : 4'hx;
    chk(tag, 32'(obs), 32'(e));
  endtask

  // the rotating instance's processor simply acknowledges whatever hold it saw last cycle
  task automatic step();
    @(posedge clk);
    #1;
    chk("inv_fix", 32'($onehot0(f_dack) && (f_hold || f_dack == 4'd0)), 32'd1);
    chk("inv_rot", 32'($onehot0(r_dack) && (r_hold || r_dack == 4'd0)), 32'd1);
    rh = r_hold;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; fd = 4'd0; fh = 1'b0; rd = 4'd0; rh = 1'b0;
    #12;
    chk("rst_hold", 32'(f_hold), 32'd0);
    chk("rst_dack", 32'(f_dack), 32'd0);
    chk("rst_busy", 32'(f_busy), 32'd0);
    chk("rst_abort", 32'(f_abort), 32'd0);
    chk("rst_state", 32'(f_state), 32'd0);
    chk("rst_rot_state", 32'(r_state), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_after_rst", 32'(f_state), 32'd0);

    rd = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    for (int t = 0; t < 5; t++) begin
      gap = 0;
      for (int k = 0; k < 30 && r_dack == 4'd0; k++) begin
        if (!r_hold) gap++;
        step();
      end
      pop_grant("rot_grant", r_dack);
      if (t > 0) chk("rot_gap", 32'(gap >= 1), 32'd1);
      cnt = 0;
      for (int k = 0; k < 30 && r_dack != 4'd0; k++) begin
        cnt++;
        step();
      end
      chk("rot_len", 32'(cnt), 32'd4);
    end
    rd = 4'd0;

    fd = 4'b0110;
    step();
    chk("fix_req_state", 32'(f_state), 32'd1);
    chk("fix_req_hold", 32'(f_hold), 32'd1);
    chk("fix_req_dack", 32'(f_dack), 32'd0);
    chk("fix_req_busy", 32'(f_busy), 32'd1);
    step();
    step();
    chk("fix_req_wait", 32'(f_state), 32'd1);
    fh = 1'b1;
    exp_q.push_back(4'b0010);
    step();
    pop_grant("fix_grant1", f_dack);
    step();
    step();
    chk("fix_grant_hold", 32'(f_hold), 32'd1);
    chk("fix_grant_keep", 32'(f_dack), 32'b0010);
    fd = 4'b0100;
    step();
    chk("fix_rel_state", 32'(f_state), 32'd3);
    chk("fix_rel_hold", 32'(f_hold), 32'd0);
    chk("fix_rel_dack", 32'(f_dack), 32'd0);
    chk("fix_rel_busy", 32'(f_busy), 32'd1);
    step();
    chk("fix_rel_stay", 32'(f_state), 32'd3);
    fh = 1'b0;
    step();
    chk("fix_idle_gap", 32'(f_state), 32'd0);
    chk("fix_idle_hold", 32'(f_hold), 32'd0);
    step();
    chk("fix_rehold", 32'(f_hold), 32'd1);
    fh = 1'b1;
    exp_q.push_back(4'b0100);
    step();
    pop_grant("fix_grant2", f_dack);

    cnt = 0;
    for (int k = 0; k < 40 && f_dack == 4'b0100; k++) begin
      cnt++;
      step();
    end
    chk("beat_len", 32'(cnt), 32'd16);
    chk("beat_hold", 32'(f_hold), 32'd0);
    chk("beat_dack", 32'(f_dack), 32'd0);
    chk("beat_state", 32'(f_state), 32'd3);
    chk("beat_no_abort", 32'(f_abort), 32'd0);
    fh = 1'b0; fd = 4'd0;
    step();
    chk("beat_idle", 32'(f_state), 32'd0);

    fd = 4'b0001;
    step();
    fh = 1'b1;
    exp_q.push_back(4'b0001);
    step();
    pop_grant("abort_grant", f_dack);
    step();
    fh = 1'b0;
    step();
    chk("abort_pulse", 32'(f_abort), 32'd1);
    chk("abort_hold", 32'(f_hold), 32'd0);
    chk("abort_dack", 32'(f_dack), 32'd0);
    fd = 4'd0;
    step();
    chk("abort_once", 32'(f_abort), 32'd0);
    chk("abort_idle", 32'(f_state), 32'd0);

    fd = 4'b0001;
    step();
    chk("wd_req", 32'(f_state), 32'd1);
    chk("wd_req_dack", 32'(f_dack), 32'd0);
    fd = 4'd0;
    step();
    chk("wd_rel", 32'(f_state), 32'd3);
    chk("wd_rel_dack", 32'(f_dack), 32'd0);
    step();
    chk("wd_idle", 32'(f_state), 32'd0);
    chk("wd_idle_dack", 32'(f_dack), 32'd0);

    fd = 4'b0001;
    step();
    fh = 1'b1;
    step();
    chk("ar_grant", 32'(f_state), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_hold", 32'(f_hold), 32'd0);
    chk("ar_dack", 32'(f_dack), 32'd0);
    chk("ar_busy", 32'(f_busy), 32'd0);
    chk("ar_state", 32'(f_state), 32'd0);
    fd = 4'd0; fh = 1'b0;
    #2;
    rst = 1'b1;
    step();
    step();
    chk("ar_idle_state", 32'(f_state), 32'd0);
    chk("ar_idle_busy", 32'(f_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
